multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control_pkg.sv | 85 ++++++++
 rtl/multi_cycle_control_if.sv | 39 +++
 rtl/mem_wait_timer.sv | 27 ++
 rtl/multi_cycle_control.sv | 194 +++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// ALU operation classes, datapath select codes and the control word.
package multi_cycle_control_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXECUTE   = 4'd6,
      ALU_WB    = 4'd7,
      IMM_EXEC  = 4'd8,
      IMM_WB    = 4'd9,
      BRANCH    = 4'd10,
      JUMP      = 4'd11,
      JR        = 4'd12,
      HALT      = 4'd15
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_RTYPE = 4'd2,
      ALU_OR    = 4'd3,
      ALU_AND   = 4'd4,
      ALU_LUI   = 4'd5
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FUNCT_JR = 6'h08;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;
   localparam logic [1:0] REG_DST_RA = 2'd2;

   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;

   localparam logic       SRC_A_PC      = 1'b0;
   localparam logic       SRC_A_RS      = 1'b1;
   localparam logic [1:0] SRC_B_RT      = 2'd0;
   localparam logic [1:0] SRC_B_FOUR    = 2'd1;
   localparam logic [1:0] SRC_B_IMM     = 2'd2;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

   typedef struct packed {
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      alu_op_t    alu_op;
      logic       retire;
   } ctrl_t;

   // States in which a memory access is outstanding and the wait timer runs.
   function automatic logic is_mem_state(input state_t s);
      return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
   endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the master.
// Memory handshake: a strobe (mem_read_o/mem_write_o) stays high with a stable
// address select until the cycle mem_ready_i is high; that cycle completes it.
interface multi_cycle_control_if;
   logic [5:0] opcode_i;
   logic [5:0] funct_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       i_or_d_o;
   logic       mem_read_o;
   logic       mem_write_o;
   logic       ir_write_o;
   logic       pc_write_o;
   logic [1:0] pc_src_o;
   logic       reg_write_o;
   logic [1:0] reg_dst_o;
   logic [1:0] mem_to_reg_o;
   logic       alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic [3:0] alu_op_o;
   logic [3:0] state_o;
   logic       retire_o;
   logic       illegal_o;
   logic       timeout_o;

   modport master (
      input  opcode_i, funct_i, zero_i, mem_ready_i,
      output i_or_d_o, mem_read_o, mem_write_o, ir_write_o, pc_write_o, pc_src_o,
             reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
             alu_op_o, state_o, retire_o, illegal_o, timeout_o
   );

   modport slave (
      output opcode_i, funct_i, zero_i, mem_ready_i,
      input  i_or_d_o, mem_read_o, mem_write_o, ir_write_o, pc_write_o, pc_src_o,
             reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
             alu_op_o, state_o, retire_o, illegal_o, timeout_o
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts unanswered cycles of a memory access; expired flags the last allowed
// cycle so the controller can leave for HALT on the following edge.
module mem_wait_timer #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic active,
   input  logic ready,
   output logic expired
);
   localparam int CW = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset || start) begin
         cnt_q <= '0;
      end else if (active && !ready) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = active && !ready && (cnt_q == LAST);
endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: one state per instruction phase, memory
// strobes held until mem_ready_i, sticky illegal/timeout flags ending in HALT.
module multi_cycle_control
   import multi_cycle_control_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   multi_cycle_control_if.master bus
);
   state_t state_q, state_d;
   ctrl_t  ctl, ctl_g;
   logic   illegal_q, timeout_q;
   logic   set_illegal, set_timeout;
   logic   wait_expired;

   mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (state_d != state_q),
      .active  (is_mem_state(state_q)),
      .ready   (bus.mem_ready_i),
      .expired (wait_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (set_illegal) illegal_q <= 1'b1;
         if (set_timeout) timeout_q <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      ctl         = '0;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      case (state_q)
         FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_a = SRC_A_PC;
            ctl.alu_src_b = SRC_B_FOUR;
            ctl.alu_op    = ALU_ADD;
            ctl.pc_src    = PC_SRC_ALU;
            if (bus.mem_ready_i) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
               state_d      = DECODE;
            end else if (wait_expired) begin
               state_d     = HALT;
               set_timeout = 1'b1;
            end
         end
         DECODE: begin
            // ALUOut captures PC+4 + (imm<<2) for a possible branch.
            ctl.alu_src_a = SRC_A_PC;
            ctl.alu_src_b = SRC_B_IMM_SH2;
            ctl.alu_op    = ALU_ADD;
            case (bus.opcode_i)
               OP_LW, OP_SW:                     state_d = MEM_ADDR;
               OP_RTYPE:                         state_d = (bus.funct_i == FUNCT_JR) ? JR : EXECUTE;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = IMM_EXEC;
               OP_BEQ, OP_BNE:                   state_d = BRANCH;
               OP_J, OP_JAL:                     state_d = JUMP;
               default: begin
                  state_d     = HALT;
                  set_illegal = 1'b1;
               end
            endcase
         end
         MEM_ADDR: begin
            ctl.alu_src_a = SRC_A_RS;
            ctl.alu_src_b = SRC_B_IMM;
            ctl.alu_op    = ALU_ADD;
            state_d       = (bus.opcode_i == OP_SW) ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            ctl.i_or_d   = 1'b1;
            ctl.mem_read = 1'b1;
            if (bus.mem_ready_i) begin
               state_d = MEM_WB;
            end else if (wait_expired) begin
               state_d     = HALT;
               set_timeout = 1'b1;
            end
         end
         MEM_WRITE: begin
            ctl.i_or_d    = 1'b1;
            ctl.mem_write = 1'b1;
            if (bus.mem_ready_i) begin
               ctl.retire = 1'b1;
               state_d    = FETCH;
            end else if (wait_expired) begin
               state_d     = HALT;
               set_timeout = 1'b1;
            end
         end
         MEM_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = REG_DST_RT;
            ctl.mem_to_reg = WB_MDR;
            ctl.retire     = 1'b1;
            state_d        = FETCH;
         end
         EXECUTE: begin
            ctl.alu_src_a = SRC_A_RS;
            ctl.alu_src_b = SRC_B_RT;
            ctl.alu_op    = ALU_RTYPE;
            state_d       = ALU_WB;
         end
         ALU_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = REG_DST_RD;
            ctl.mem_to_reg = WB_ALUOUT;
            ctl.retire     = 1'b1;
            state_d        = FETCH;
         end
         IMM_EXEC: begin
            ctl.alu_src_a = SRC_A_RS;
            ctl.alu_src_b = SRC_B_IMM;
            case (bus.opcode_i)
               OP_ANDI: ctl.alu_op = ALU_AND;
               OP_ORI:  ctl.alu_op = ALU_OR;
               OP_LUI:  ctl.alu_op = ALU_LUI;
               default: ctl.alu_op = ALU_ADD;
            endcase
            state_d = IMM_WB;
         end
         IMM_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = REG_DST_RT;
            ctl.mem_to_reg = WB_ALUOUT;
            ctl.retire     = 1'b1;
            state_d        = FETCH;
         end
         BRANCH: begin
            ctl.alu_src_a = SRC_A_RS;
            ctl.alu_src_b = SRC_B_RT;
            ctl.alu_op    = ALU_SUB;
            ctl.pc_src    = PC_SRC_ALUOUT;
            ctl.pc_write  = ((bus.opcode_i == OP_BEQ) &&  bus.zero_i) ||
                            ((bus.opcode_i == OP_BNE) && !bus.zero_i);
            ctl.retire    = 1'b1;
            state_d       = FETCH;
         end
         JUMP: begin
            ctl.pc_src   = PC_SRC_JUMP;
            ctl.pc_write = 1'b1;
            // jal links PC+4 into $ra in the same cycle as the jump.
            if (bus.opcode_i == OP_JAL) begin
               ctl.reg_write  = 1'b1;
               ctl.reg_dst    = REG_DST_RA;
               ctl.mem_to_reg = WB_PC;
            end
            ctl.retire = 1'b1;
            state_d    = FETCH;
         end
         JR: begin
            ctl.pc_src   = PC_SRC_RS;
            ctl.pc_write = 1'b1;
            ctl.retire   = 1'b1;
            state_d      = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = HALT;
      endcase
   end

   // Nothing reaches the datapath or memory while reset is held low.
   assign ctl_g = reset ? ctl : '0;

   assign bus.i_or_d_o     = ctl_g.i_or_d;
   assign bus.mem_read_o   = ctl_g.mem_read;
   assign bus.mem_write_o  = ctl_g.mem_write;
   assign bus.ir_write_o   = ctl_g.ir_write;
   assign bus.pc_write_o   = ctl_g.pc_write;
   assign bus.pc_src_o     = ctl_g.pc_src;
   assign bus.reg_write_o  = ctl_g.reg_write;
   assign bus.reg_dst_o    = ctl_g.reg_dst;
   assign bus.mem_to_reg_o = ctl_g.mem_to_reg;
   assign bus.alu_src_a_o  = ctl_g.alu_src_a;
   assign bus.alu_src_b_o  = ctl_g.alu_src_b;
   assign bus.alu_op_o     = ctl_g.alu_op;
   assign bus.retire_o     = ctl_g.retire;
   assign bus.state_o      = state_q;
   assign bus.illegal_o    = illegal_q;
   assign bus.timeout_o    = timeout_q;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle expected control words are
// queued as each cycle is driven and popped/compared on the falling edge.
module tb_multi_cycle_control;

   typedef struct packed {
      logic [3:0] st;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic       retire;
      logic       illegal;
      logic       timeout;
   } obs_t;

   localparam int W = $bits(obs_t);

   logic clk;
   logic reset;
   logic [W-1:0] exp_q[$];
   int   n_tests;
   int   n_fail;
   int   cyc_n;
   logic exp_ill;
   logic exp_to;
   string cur_tag;

   multi_cycle_control_if bus ();

   multi_cycle_control #(.MEM_WAIT_MAX(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- expected control words ----------------
   function automatic obs_t z0(input logic [3:0] st);
      obs_t e;
      e    = '0;
      e.st = st;
      return e;
   endfunction

   function automatic obs_t e_fetch(input logic rdy);
      obs_t e = z0(4'd0);
      e.mem_read = 1'b1; e.alu_src_b = 2'd1; e.ir_write = rdy; e.pc_write = rdy;
      return e;
   endfunction

   function automatic obs_t e_decode();
      obs_t e = z0(4'd1);
      e.alu_src_b = 2'd3;
      return e;
   endfunction

   function automatic obs_t e_mem_addr();
      obs_t e = z0(4'd2);
      e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
      return e;
   endfunction

   function automatic obs_t e_mem_read();
      obs_t e = z0(4'd3);
      e.i_or_d = 1'b1; e.mem_read = 1'b1;
      return e;
   endfunction

   function automatic obs_t e_mem_write(input logic rdy);
      obs_t e = z0(4'd5);
      e.i_or_d = 1'b1; e.mem_write = 1'b1; e.retire = rdy;
      return e;
   endfunction

   function automatic obs_t e_mem_wb();
      obs_t e = z0(4'd4);
      e.reg_write = 1'b1; e.mem_to_reg = 2'd1; e.retire = 1'b1;
      return e;
   endfunction

   function automatic obs_t e_execute();
      obs_t e = z0(4'd6);
      e.alu_src_a = 1'b1; e.alu_op = 4'd2;
      return e;
   endfunction

   function automatic obs_t e_alu_wb();
      obs_t e = z0(4'd7);
      e.reg_write = 1'b1; e.reg_dst = 2'd1; e.retire = 1'b1;
      return e;
   endfunction

   function automatic obs_t e_imm_exec(input logic [3:0] op);
      obs_t e = z0(4'd8);
      e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = op;
      return e;
   endfunction

   function automatic obs_t e_imm_wb();
      obs_t e = z0(4'd9);
      e.reg_write = 1'b1; e.retire = 1'b1;
      return e;
   endfunction

   function automatic obs_t e_branch(input logic pcw);
      obs_t e = z0(4'd10);
      e.alu_src_a = 1'b1; e.alu_op = 4'd1; e.pc_src = 2'd1; e.pc_write = pcw; e.retire = 1'b1;
      return e;
   endfunction

   function automatic obs_t e_jump(input logic link);
      obs_t e = z0(4'd11);
      e.pc_src = 2'd2; e.pc_write = 1'b1; e.retire = 1'b1;
      if (link) begin
         e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
      end
      return e;
   endfunction

   function automatic obs_t e_jr();
      obs_t e = z0(4'd12);
      e.pc_src = 2'd3; e.pc_write = 1'b1; e.retire = 1'b1;
      return e;
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // ---------------- driver / scoreboard ----------------
   task automatic check_cycle();
      obs_t       o;
      logic [W-1:0] ov, ex;
      o = '{bus.state_o, bus.i_or_d_o, bus.mem_read_o, bus.mem_write_o, bus.ir_write_o,
            bus.pc_write_o, bus.pc_src_o, bus.reg_write_o, bus.reg_dst_o, bus.mem_to_reg_o,
            bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.retire_o, bus.illegal_o,
            bus.timeout_o};
      ov = o;
      ex = exp_q.pop_front();
      n_tests++;
      assert (ov === ex) else begin
         n_fail++;
         $error("FAIL %s_c%0d observed=%h expected=%h (state %0d vs %0d)",
                cur_tag, cyc_n, ov, ex, ov[W-1 -: 4], ex[W-1 -: 4]);
      end
   endtask

   // One clock: queue the expected word, drive inputs, compare at negedge.
   task automatic cyc(input obs_t e, input logic rdy, input logic z);
      logic [W-1:0] v;
      e.illegal = exp_ill;
      e.timeout = exp_to;
      v = e;
      exp_q.push_back(v);
      bus.mem_ready_i = rdy;
      bus.zero_i      = z;
      cyc_n++;
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [31:0] ins, input string tag);
      bus.opcode_i = ins[31:26];
      bus.funct_i  = ins[5:0];
      cur_tag      = tag;
      cyc_n        = 0;
   endtask

   // Reset low for one edge: outputs gated, state/flags still show old values.
   task automatic do_reset(input logic [3:0] st_before, input string tag);
      cur_tag = tag;
      cyc_n   = 0;
      reset   = 1'b0;
      cyc(z0(st_before), rnd(), rnd());
      exp_ill = 1'b0;
      exp_to  = 1'b0;
      reset   = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   logic [31:0] imm_ins[4] = '{32'h21280005, 32'h3128000F, 32'h35280F0F, 32'h3C081234};
   logic [3:0]  imm_op[4]  = '{4'd0, 4'd4, 4'd3, 4'd5};
   logic [31:0] br_ins[4]  = '{32'h11090003, 32'h11090003, 32'h15090003, 32'h15090003};
   logic        br_z[4]    = '{1'b1, 1'b0, 1'b0, 1'b1};
   logic        br_pcw[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      n_tests = 0; n_fail = 0; cyc_n = 0;
      exp_ill = 1'b0; exp_to = 1'b0;
      reset = 1'b0;
      bus.opcode_i = '0; bus.funct_i = '0; bus.zero_i = 1'b0; bus.mem_ready_i = 1'b0;
      @(posedge clk);
      #1;

      cur_tag = "reset";
      cyc(z0(4'd0), 1'b1, rnd());
      cyc(z0(4'd0), 1'b1, rnd());
      reset = 1'b1;

      set_instr(32'h012A4020, "add");
      cyc(e_fetch(1'b1), 1'b1, rnd());
      cyc(e_decode(),    1'b1, rnd());
      cyc(e_execute(),   1'b1, rnd());
      cyc(e_alu_wb(),    1'b1, rnd());

      set_instr(32'h8D280004, "lw_wait3");
      cyc(e_fetch(1'b1), 1'b1, rnd());
      cyc(e_decode(),    rnd(), rnd());
      cyc(e_mem_addr(),  rnd(), rnd());
      for (int i = 0; i < 3; i++) cyc(e_mem_read(), 1'b0, rnd());
      cyc(e_mem_read(),  1'b1, rnd());
      cyc(e_mem_wb(),    rnd(), rnd());

      set_instr(32'hAD280004, "sw");
      cyc(e_fetch(1'b1),     1'b1, rnd());
      cyc(e_decode(),        rnd(), rnd());
      cyc(e_mem_addr(),      rnd(), rnd());
      cyc(e_mem_write(1'b1), 1'b1, rnd());

      for (int i = 0; i < 4; i++) begin
         set_instr(imm_ins[i], $sformatf("imm%0d", i));
         cyc(e_fetch(1'b1),          1'b1, rnd());
         cyc(e_decode(),             rnd(), rnd());
         cyc(e_imm_exec(imm_op[i]),  rnd(), rnd());
         cyc(e_imm_wb(),             rnd(), rnd());
      end

      for (int i = 0; i < 4; i++) begin
         set_instr(br_ins[i], $sformatf("branch%0d", i));
         cyc(e_fetch(1'b1),        1'b1, rnd());
         cyc(e_decode(),           rnd(), rnd());
         cyc(e_branch(br_pcw[i]),  rnd(), br_z[i]);
      end

      set_instr(32'h08000010, "j");
      cyc(e_fetch(1'b1), 1'b1, rnd());
      cyc(e_decode(),    rnd(), rnd());
      cyc(e_jump(1'b0),  rnd(), rnd());

      set_instr(32'h0C000010, "jal");
      cyc(e_fetch(1'b1), 1'b1, rnd());
      cyc(e_decode(),    rnd(), rnd());
      cyc(e_jump(1'b1),  rnd(), rnd());

      set_instr(32'h03E00008, "jr");
      cyc(e_fetch(1'b0), 1'b0, rnd());
      cyc(e_fetch(1'b0), 1'b0, rnd());
      cyc(e_fetch(1'b1), 1'b1, rnd());
      cyc(e_decode(),    rnd(), rnd());
      cyc(e_jr(),        rnd(), rnd());

      set_instr(32'hFC000000, "illegal");
      cyc(e_fetch(1'b1), 1'b1, rnd());
      cyc(e_decode(),    rnd(), rnd());
      exp_ill = 1'b1;
      for (int i = 0; i < 3; i++) cyc(z0(4'd15), rnd(), rnd());
      do_reset(4'd15, "illegal_reset");

      set_instr(32'h012A4020, "timeout");
      for (int i = 0; i < 15; i++) cyc(e_fetch(1'b0), 1'b0, rnd());
      exp_to = 1'b1;
      for (int i = 0; i < 3; i++) cyc(z0(4'd15), rnd(), rnd());
      do_reset(4'd15, "timeout_reset");

      set_instr(32'hAD280004, "sw_reset");
      cyc(e_fetch(1'b1),     1'b1, rnd());
      cyc(e_decode(),        rnd(), rnd());
      cyc(e_mem_addr(),      rnd(), rnd());
      cyc(e_mem_write(1'b0), 1'b0, rnd());
      cyc(e_mem_write(1'b0), 1'b0, rnd());
      do_reset(4'd5, "sw_reset_mid");

      set_instr(32'h012A4020, "add_after_reset");
      cyc(e_fetch(1'b1), 1'b1, rnd());
      cyc(e_decode(),    rnd(), rnd());
      cyc(e_execute(),   rnd(), rnd());
      cyc(e_alu_wb(),    rnd(), rnd());

      n_tests++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
